// File: rtl/usrt_rx_deserializer.sv
// USRT receive deserializer: one line sample per i_Pclk rising edge, start-bit
// detection, LSB-first data capture, optional parity bit, stop-bit check.
// Emits an 11-bit frame {stop, parity, data[7:0], start} with a one-cycle
// o_Valid strobe for the downstream parity checker.
// Optional feature: define USRT_RX_BREAK_DETECT_EN to report an all-zero frame
// as a break (o_Break pulse) instead of a framing-error frame.
module usrt_rx_deserializer #(
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic        i_Pclk,
   input  logic        i_Rst,
   input  logic        i_Rx,
   input  logic [1:0]  i_Parity,
   output logic [10:0] o_Frame,
   output logic        o_Valid,
   output logic        o_FrameErr,
   output logic        o_Break,
   output logic        o_Busy
);

`ifdef USRT_RX_BREAK_DETECT_EN
   localparam logic BRK_EN = 1'b1;
`else
   localparam logic BRK_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_RECOVER
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] frame_q, frame_d;     // frame being assembled
   logic [2:0]  cnt_q, cnt_d;         // data bit index 0..7
   logic [1:0]  par_q, par_d;         // parity mode latched at the start bit
   logic [10:0] oframe_q, oframe_d;   // last completed frame
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        brk_q, brk_d;

   logic        start_seen;
   logic        par_en;
   logic        stop_bad;
   logic        all_zero;

   assign start_seen = (i_Rx != IDLE_LEVEL);
   // Only modes 01 (even) and 10 (odd) carry a parity bit on the line.
   assign par_en     = ^par_q;
   assign stop_bad   = (i_Rx != IDLE_LEVEL);
   // Frame bit 9 stays 0 when no parity bit is sent, so the whole word works.
   assign all_zero   = ({i_Rx, frame_q[9:0]} == 11'd0);

   // State register
   always_ff @(posedge i_Pclk) begin
      if (i_Rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start_seen) state_d = S_DATA;
         S_DATA:    if (cnt_q == 3'd7) state_d = par_en ? S_PARITY : S_STOP;
         S_PARITY:  state_d = S_STOP;
         S_STOP: begin
            if ((BRK_EN && all_zero) || stop_bad) state_d = S_RECOVER;
            else                                  state_d = S_IDLE;
         end
         S_RECOVER: if (i_Rx == IDLE_LEVEL) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      frame_d  = frame_q;
      cnt_d    = cnt_q;
      par_d    = par_q;
      oframe_d = oframe_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      brk_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_seen) begin
               frame_d = {10'd0, i_Rx};
               par_d   = i_Parity;
               cnt_d   = 3'd0;
            end
         end
         S_DATA: begin
            frame_d[{1'b0, cnt_q} + 4'd1] = i_Rx;
            cnt_d = cnt_q + 3'd1;
         end
         S_PARITY: frame_d[9] = i_Rx;
         S_STOP: begin
            frame_d[10] = i_Rx;
            if (BRK_EN && all_zero) begin
               brk_d = 1'b1;
            end else begin
               oframe_d = {i_Rx, frame_q[9:0]};
               valid_d  = 1'b1;
               ferr_d   = stop_bad;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset drops any partial frame
   always_ff @(posedge i_Pclk) begin
      if (i_Rst) begin
         frame_q  <= '0;
         cnt_q    <= '0;
         par_q    <= '0;
         oframe_q <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         brk_q    <= 1'b0;
      end else begin
         frame_q  <= frame_d;
         cnt_q    <= cnt_d;
         par_q    <= par_d;
         oframe_q <= oframe_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         brk_q    <= brk_d;
      end
   end

   assign o_Frame    = oframe_q;
   assign o_Valid    = valid_q;
   assign o_FrameErr = ferr_q;
   assign o_Break    = brk_q;
   assign o_Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_usrt_rx_deserializer.sv
// Directed bench for usrt_rx_deserializer: reset, parity/no-parity frames,
// back-to-back frames, framing error with recovery, mid-frame reset, and the
// all-zero line (break or error frame depending on USRT_RX_BREAK_DETECT_EN).
module tb_usrt_rx_deserializer;

   logic        i_Pclk;
   logic        i_Rst;
   logic        i_Rx;
   logic [1:0]  i_Parity;
   logic [10:0] o_Frame;
   logic        o_Valid;
   logic        o_FrameErr;
   logic        o_Break;
   logic        o_Busy;

   int total = 0;
   int bad   = 0;
   int nvalid = 0;
   int nv;
   logic [7:0] d;

   usrt_rx_deserializer #(.IDLE_LEVEL(1'b1)) dut (
      .i_Pclk     (i_Pclk),
      .i_Rst      (i_Rst),
      .i_Rx       (i_Rx),
      .i_Parity   (i_Parity),
      .o_Frame    (o_Frame),
      .o_Valid    (o_Valid),
      .o_FrameErr (o_FrameErr),
      .o_Break    (o_Break),
      .o_Busy     (o_Busy)
   );

   initial i_Pclk = 1'b0;
   always #5 i_Pclk = ~i_Pclk;

   // Count valid pulses on the falling edge, away from the sampling edge.
   always @(negedge i_Pclk) if (o_Valid === 1'b1) nvalid++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Drive one line bit, let the DUT sample it, then settle just past the edge.
   task automatic send_bit(input logic b);
      i_Rx = b;
      @(posedge i_Pclk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic has_par,
                             input logic pbit, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      if (has_par) send_bit(pbit);
      send_bit(stop);
   endtask

   initial begin
      i_Rst = 1'b1; i_Rx = 1'b1; i_Parity = 2'b00;
      repeat (3) @(posedge i_Pclk);
      #1;
      chk("rst_valid", o_Valid, 0);
      chk("rst_ferr",  o_FrameErr, 0);
      chk("rst_break", o_Break, 0);
      chk("rst_busy",  o_Busy, 0);
      chk("rst_frame", o_Frame, 0);
      i_Rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_bit(1'b1);
         chk("idle_busy", o_Busy, 0);
      end
      chk("idle_nvalid", nvalid, 0);

      // Even parity, 0xA5; mode change after the start bit must be ignored.
      i_Parity = 2'b01;
      nv = nvalid;
      send_bit(1'b0);
      i_Parity = 2'b00;
      d = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i]);
         if (i == 0) chk("t2_busy", o_Busy, 1);
      end
      send_bit(1'b0);
      chk("t2_novalid_par", o_Valid, 0);
      send_bit(1'b1);
      chk("t2_valid", o_Valid, 1);
      chk("t2_frame", o_Frame, 11'h54A);
      chk("t2_ferr",  o_FrameErr, 0);
      chk("t2_busy_end", o_Busy, 0);
      send_bit(1'b1);
      chk("t2_pulse", o_Valid, 0);
      chk("t2_count", nvalid, nv + 1);

      // No parity, back-to-back 0x3C then 0xC3 with no idle gap.
      i_Parity = 2'b00;
      nv = nvalid;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      chk("t3_valid1", o_Valid, 1);
      chk("t3_frame1", o_Frame, 11'h478);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      chk("t3_valid2", o_Valid, 1);
      chk("t3_frame2", o_Frame, 11'h586);
      chk("t3_ferr2",  o_FrameErr, 0);
      send_bit(1'b1);
      chk("t3_pulse", o_Valid, 0);
      chk("t3_count", nvalid, nv + 2);

      // Odd parity, 0x01, bad stop, line held low then released.
      i_Parity = 2'b10;
      nv = nvalid;
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      chk("t4_valid", o_Valid, 1);
      chk("t4_ferr",  o_FrameErr, 1);
      chk("t4_frame", o_Frame, 11'h002);
      chk("t4_busy",  o_Busy, 1);
      for (int i = 0; i < 4; i++) begin
         send_bit(1'b0);
         chk("t4_recover_busy", o_Busy, 1);
         chk("t4_recover_valid", o_Valid, 0);
         chk("t4_recover_ferr", o_FrameErr, 0);
      end
      send_bit(1'b1);
      chk("t4_idle_busy", o_Busy, 0);
      send_bit(1'b1);
      chk("t4_count", nvalid, nv + 1);

      // Reset at data bit 4 discards the frame.
      i_Parity = 2'b00;
      nv = nvalid;
      send_bit(1'b0);
      d = 8'h0F;
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      i_Rst = 1'b1;
      send_bit(1'b0);
      i_Rst = 1'b0;
      chk("t5_rst_busy",  o_Busy, 0);
      chk("t5_rst_frame", o_Frame, 0);
      chk("t5_rst_ferr",  o_FrameErr, 0);
      for (int i = 0; i < 11; i++) send_bit(1'b1);
      chk("t5_no_valid", nvalid, nv);
      chk("t5_busy", o_Busy, 0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      chk("t5_valid", o_Valid, 1);
      chk("t5_frame", o_Frame, 11'h4B4);
      chk("t5_ferr",  o_FrameErr, 0);
      send_bit(1'b1);

      // Line low for 12 cycles with even parity selected.
      i_Parity = 2'b01;
      nv = nvalid;
      for (int i = 0; i < 12; i++) begin
         send_bit(1'b0);
         if (i == 10) begin
`ifdef USRT_RX_BREAK_DETECT_EN
            chk("t6_break", o_Break, 1);
            chk("t6_valid", o_Valid, 0);
            chk("t6_ferr",  o_FrameErr, 0);
            chk("t6_frame", o_Frame, 11'h4B4);
`else
            chk("t6_break", o_Break, 0);
            chk("t6_valid", o_Valid, 1);
            chk("t6_ferr",  o_FrameErr, 1);
            chk("t6_frame", o_Frame, 11'h000);
`endif
         end
         if (i == 11) begin
            chk("t6_pulse_valid", o_Valid, 0);
            chk("t6_pulse_break", o_Break, 0);
            chk("t6_busy", o_Busy, 1);
         end
      end
      send_bit(1'b1);
      chk("t6_idle_busy", o_Busy, 0);
      send_bit(1'b1);
`ifdef USRT_RX_BREAK_DETECT_EN
      chk("t6_count", nvalid, nv);
`else
      chk("t6_count", nvalid, nv + 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usrt_rx_deserializer.md
Name: usrt_rx_deserializer

Overview:
- Receive front end of the USRT.
- Samples the serial line once per i_Pclk edge (synchronous link, one bit per clock), finds the start bit and shifts in the rest of the frame.
- Presents the assembled 11-bit frame with a one-cycle valid strobe to the downstream parity checker.
- Frame layout on o_Frame: [0] start, [8:1] data LSB first, [9] parity, [10] stop.

Parameters:
- IDLE_LEVEL, 1, logic level of the idle line; the start bit is the opposite level.

Ports:
- i_Pclk  input  1  clock; line sampled on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_Rx  input  1  serial line, already synchronous to i_Pclk
- i_Parity  input  2  00 none, 01 even, 10 odd, 11 none; latched at start bit
- o_Frame  output  11  last received frame; held until next completion
- o_Valid  output  1  one-cycle pulse: o_Frame updated
- o_FrameErr  output  1  one-cycle pulse with o_Valid: stop bit sampled as 0
- o_Break  output  1  one-cycle pulse: break detected (feature only; else 0)
- o_Busy  output  1  high from the edge after start detection until return to IDLE

Behaviour:
- Reset, with i_Rst high at an edge:
  - state=IDLE; all outputs 0; shift register and bit counter cleared.
  - Reset mid-frame discards the partial frame and produces no o_Valid.
- States: IDLE, DATA, PARITY, STOP, RECOVER.
- IDLE:
  - i_Rx != IDLE_LEVEL at edge k is the start bit.
  - Store it as frame[0], latch i_Parity, clear bit_cnt, go to DATA.
- DATA:
  - Edges k+1..k+8 shift into frame[1..8], LSB first; 3-bit bit_cnt counts 0..7.
  - At bit_cnt=7: go to PARITY if the latched mode is 01/10, else go to STOP with frame[9]=0.
- PARITY: edge k+9 stores frame[9], then go to STOP.
- STOP:
  - The stop edge is k+10 with parity, k+9 without; it stores frame[10].
  - Registered outputs: o_Frame<=frame, o_Valid<=1 in the cycle after the stop edge.
  - Stop bit is 1: o_FrameErr<=0, go to IDLE. The very next edge may detect a new start bit (back-to-back frames, no gap required).
  - Stop bit is 0: o_FrameErr<=1, go to RECOVER.
- RECOVER:
  - Wait until i_Rx==IDLE_LEVEL at an edge, then go to IDLE.
  - A low line held after an error never produces spurious frames.
- Pulses: o_Valid, o_FrameErr and o_Break are high for exactly one cycle.
- o_Busy: 1 in DATA/PARITY/STOP/RECOVER, 0 in IDLE.
- i_Parity changes mid-frame are ignored until the next start bit.
- No backpressure: the consumer must take o_Frame within the minimum inter-frame spacing (10 clocks).

Optional Feature:
- Macro: USRT_RX_BREAK_DETECT_EN.
- Defined:
  - If every sampled bit of the frame (start, data, parity if present, stop) is 0, pulse o_Break instead of o_Valid/o_FrameErr. o_Frame is not updated.
  - Enter RECOVER.
- Undefined:
  - o_Break tied 0.
  - An all-zero frame is reported as o_Valid=1, o_FrameErr=1, o_Frame=0x000.

Test Plan:
- Reset held 3 cycles mid-idle -> all outputs 0; release with i_Rx=1 for 5 cycles -> o_Busy stays 0, no o_Valid.
- i_Parity=01, send start 0, data 0xA5 LSB first, parity 0, stop 1 -> o_Valid one cycle after stop edge, o_Frame=0x54A, o_FrameErr=0.
- i_Parity=00, send 0x3C, then next start bit on the edge immediately after the stop bit with 0xC3 -> two o_Valid pulses 10 cycles apart, o_Frame=0x478 then 0x586.
- i_Parity=10, data 0x01, parity 0, stop 0, line held low 4 more cycles -> o_Valid+o_FrameErr pulse, o_Frame=0x002, no new frame until line returns high.
- Assert i_Rst at data bit 4 of a frame -> no o_Valid; next full frame 0x5A (parity none) -> o_Frame=0x4B4.
- Line low 12 cycles, i_Parity=01 -> with USRT_RX_BREAK_DETECT_EN: o_Break pulse, o_Valid stays 0; without: o_Valid=1, o_FrameErr=1, o_Frame=0x000.
